// File: rtl/array_loader_if.sv
// array_loader_if: row-word stream into the array loader.
// Source drives valid/data/parity, loader answers with ready.
interface array_loader_if #(
    parameter int COLS = 16
) ();
    logic            IN_VALID;
    logic            IN_READY;
    logic [COLS-1:0] IN_DATA;
    logic            IN_PARITY;

    modport master (
        output IN_VALID,
        output IN_DATA,
        output IN_PARITY,
        input  IN_READY
    );

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        input  IN_PARITY,
        output IN_READY
    );
endinterface

// File: rtl/array_loader.sv
// array_loader: double-buffered ROWS x COLS frame loader.
// Define ARRAY_LOADER_PARITY_EN to compile in even-parity checking.
module array_loader #(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic                     FPGA_CLK_50,
    input  logic                     RESET_N,
    input  logic                     START,
    input  logic                     ABORT,
    array_loader_if.slave            in_if,
    output logic [ROWS*COLS-1:0]     ARRAY_OUT,
    output logic                     ARRAY_VALID,
    output logic                     BUSY,
    output logic                     ERROR,
    output logic [$clog2(ROWS)-1:0]  ROW_CNT
);
    localparam int CW = $clog2(ROWS);
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              row_q, row_d;
    logic [ROWS-1:0][COLS-1:0]  shadow_q, shadow_d;
    logic [ROWS*COLS-1:0]       array_q, array_d;
    logic                       valid_q, valid_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       error_q, error_d;
    logic                       accept;
    logic                       par_err;

`ifdef ARRAY_LOADER_PARITY_EN
    assign par_err = ^{in_if.IN_DATA, in_if.IN_PARITY};
`else
    logic unused_parity;
    assign unused_parity = in_if.IN_PARITY;
    assign par_err = 1'b0;
`endif

    assign accept = ready_q && in_if.IN_VALID;

    // Next-state, row counter, shadow write and commit decode
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        shadow_d = shadow_q;
        array_d  = array_q;
        valid_d  = valid_q;
        unique case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    state_d = LOAD;
                    row_d   = '0;
                end
            end
            LOAD: begin
                if (ABORT) begin
                    state_d = IDLE;
                    row_d   = '0;
                end else if (accept && par_err) begin
                    state_d = ERR;
                end else if (accept) begin
                    shadow_d[row_q] = in_if.IN_DATA;
                    if (row_q == LAST_ROW) begin
                        state_d = COMMIT;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                array_d = shadow_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                if (START) begin
                    state_d = LOAD;
                    row_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == LOAD);
        busy_d  = (state_d == LOAD) || (state_d == COMMIT);
        error_d = (state_d == ERR);
    end

    // Control state and registered outputs
    always_ff @(posedge FPGA_CLK_50) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            row_q   <= '0;
            array_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            array_q <= array_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    // Shadow buffer; stale contents are overwritten by every new frame
    always_ff @(posedge FPGA_CLK_50) begin
        shadow_q <= shadow_d;
    end

    assign in_if.IN_READY = ready_q;
    assign ARRAY_OUT      = array_q;
    assign ARRAY_VALID    = valid_q;
    assign BUSY           = busy_q;
    assign ROW_CNT        = row_q;
`ifdef ARRAY_LOADER_PARITY_EN
    assign ERROR = error_q;
`else
    logic unused_error;
    assign unused_error = error_q;
    assign ERROR = 1'b0;
`endif
endmodule

// File: tb/tb_array_loader.sv
// tb_array_loader: directed self-checking bench for array_loader.
// Parity scenario follows ARRAY_LOADER_PARITY_EN.
module tb_array_loader;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [255:0] array_out;
    logic         array_valid;
    logic         busy;
    logic         error;
    logic [3:0]   row_cnt;

    int errors = 0;
    int checks = 0;

    logic [255:0] frame_a;
    logic [255:0] frame_b;
    logic [255:0] exp_a;

    always #10 clk = ~clk;

    array_loader_if #(.COLS(16)) bus ();

    array_loader #(.ROWS(16), .COLS(16)) dut (
        .FPGA_CLK_50 (clk),
        .RESET_N     (rst_n),
        .START       (start),
        .ABORT       (abort),
        .in_if       (bus),
        .ARRAY_OUT   (array_out),
        .ARRAY_VALID (array_valid),
        .BUSY        (busy),
        .ERROR       (error),
        .ROW_CNT     (row_cnt)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = '0;
        bus.IN_PARITY = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (array_out !== '0) begin
            errors++;
            $display("FAIL reset_array got=%h exp=0", array_out);
        end
        checks++;
        if (array_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", array_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL reset_error got=%b exp=0", error);
        end
        checks++;
        if (bus.IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0", bus.IN_READY);
        end
        checks++;
        if (row_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_row got=%0d exp=0", row_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_frame;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL load_entry busy=%b ready=%b exp=1/1", busy, bus.IN_READY);
        end
        exp_a = '0;
        for (int r = 0; r < 16; r++) begin
            checks++;
            if (row_cnt !== 4'(r)) begin
                errors++;
                $display("FAIL full_row got=%0d exp=%0d", row_cnt, r);
            end
            bus.IN_VALID  = 1'b1;
            bus.IN_DATA   = 16'(1 << r);
            bus.IN_PARITY = ^bus.IN_DATA;
            exp_a[r*16 +: 16] = 16'(1 << r);
            @(negedge clk);
        end
        bus.IN_VALID = 1'b0;
        checks++;
        if (array_valid !== 1'b0 || busy !== 1'b1 || bus.IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL full_commit valid=%b busy=%b ready=%b exp=0/1/0", array_valid, busy, bus.IN_READY);
        end
        @(negedge clk);
        checks++;
        if (array_out !== exp_a) begin
            errors++;
            $display("FAIL full_array got=%h exp=%h", array_out, exp_a);
        end
        checks++;
        if (array_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done valid=%b busy=%b exp=1/0", array_valid, busy);
        end
        frame_a = exp_a;
    endtask

    task automatic test_valid_toggle;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 31; i++) begin
            checks++;
            if (row_cnt !== 4'((i + 1) / 2)) begin
                errors++;
                $display("FAIL toggle_row i=%0d got=%0d exp=%0d", i, row_cnt, (i + 1) / 2);
            end
            bus.IN_VALID  = (i % 2 == 0);
            bus.IN_DATA   = (i % 2 == 0) ? 16'(1 << (i / 2)) : 16'hFFFF;
            bus.IN_PARITY = ^bus.IN_DATA;
            @(negedge clk);
        end
        bus.IN_VALID = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL toggle_commit busy=%b ready=%b exp=1/0", busy, bus.IN_READY);
        end
        @(negedge clk);
        checks++;
        if (array_out !== frame_a || array_valid !== 1'b1) begin
            errors++;
            $display("FAIL toggle_array got=%h v=%b exp=%h v=1", array_out, array_valid, frame_a);
        end
    endtask

    task automatic test_abort;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 7; r++) begin
            bus.IN_VALID  = 1'b1;
            bus.IN_DATA   = 16'hA5A5 ^ 16'(r);
            bus.IN_PARITY = ^bus.IN_DATA;
            @(negedge clk);
        end
        checks++;
        if (row_cnt !== 4'd7) begin
            errors++;
            $display("FAIL abort_pre_row got=%0d exp=7", row_cnt);
        end
        bus.IN_DATA   = 16'hBEEF;
        bus.IN_PARITY = ^bus.IN_DATA;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.IN_VALID = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.IN_READY !== 1'b0 || row_cnt !== 4'd0) begin
            errors++;
            $display("FAIL abort_idle busy=%b ready=%b row=%0d exp=0/0/0", busy, bus.IN_READY, row_cnt);
        end
        checks++;
        if (array_out !== frame_a || array_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_array got=%h v=%b exp=%h v=1", array_out, array_valid, frame_a);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.IN_VALID  = 1'b1;
        bus.IN_DATA   = 16'h1234;
        bus.IN_PARITY = ^bus.IN_DATA;
        repeat (2) @(negedge clk);
        bus.IN_VALID = 1'b0;
        checks++;
        if (row_cnt !== 4'd2) begin
            errors++;
            $display("FAIL abort2_pre_row got=%0d exp=2", row_cnt);
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || row_cnt !== 4'd0 || bus.IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL abort_start busy=%b row=%0d ready=%b exp=0/0/0", busy, row_cnt, bus.IN_READY);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || array_out !== frame_a) begin
            errors++;
            $display("FAIL abort_start_hold busy=%b got=%h exp=%h", busy, array_out, frame_a);
        end
    endtask

    task automatic test_start_ignored;
        frame_b = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            checks++;
            if (row_cnt !== 4'(r)) begin
                errors++;
                $display("FAIL startign_row got=%0d exp=%0d", row_cnt, r);
            end
            start = (r >= 3 && r <= 5);
            bus.IN_VALID  = 1'b1;
            bus.IN_DATA   = 16'hFFFF ^ 16'(1 << r);
            bus.IN_PARITY = ^bus.IN_DATA;
            frame_b[r*16 +: 16] = 16'hFFFF ^ 16'(1 << r);
            @(negedge clk);
        end
        start = 1'b0;
        bus.IN_VALID = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL startign_commit busy=%b ready=%b exp=1/0", busy, bus.IN_READY);
        end
        @(negedge clk);
        checks++;
        if (array_out !== frame_b || busy !== 1'b0) begin
            errors++;
            $display("FAIL startign_array got=%h busy=%b exp=%h busy=0", array_out, busy, frame_b);
        end
    endtask

`ifdef ARRAY_LOADER_PARITY_EN
    task automatic test_parity;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 4; r++) begin
            bus.IN_VALID  = 1'b1;
            bus.IN_DATA   = 16'h0101 << r;
            bus.IN_PARITY = ^bus.IN_DATA;
            @(negedge clk);
        end
        bus.IN_DATA   = 16'h0003;
        bus.IN_PARITY = 1'b1;
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        checks++;
        if (error !== 1'b1 || bus.IN_READY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL par_err error=%b ready=%b busy=%b exp=1/0/0", error, bus.IN_READY, busy);
        end
        checks++;
        if (array_out !== frame_b || array_valid !== 1'b1) begin
            errors++;
            $display("FAIL par_array got=%h v=%b exp=%h v=1", array_out, array_valid, frame_b);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL par_abort_held error=%b exp=1", error);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (error !== 1'b0 || row_cnt !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL par_restart error=%b row=%0d busy=%b exp=0/0/1", error, row_cnt, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask
`else
    task automatic test_parity;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            bus.IN_VALID  = 1'b1;
            bus.IN_DATA   = frame_a[r*16 +: 16];
            bus.IN_PARITY = ~^bus.IN_DATA;
            @(negedge clk);
            checks++;
            if (error !== 1'b0) begin
                errors++;
                $display("FAIL nopar_error r=%0d got=%b exp=0", r, error);
            end
        end
        bus.IN_VALID = 1'b0;
        @(negedge clk);
        checks++;
        if (array_out !== frame_a) begin
            errors++;
            $display("FAIL nopar_array got=%h exp=%h", array_out, frame_a);
        end
        frame_b = frame_a;
    endtask
`endif

    task automatic test_reset_mid_load;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 10; r++) begin
            bus.IN_VALID  = 1'b1;
            bus.IN_DATA   = 16'hC000 ^ 16'(r);
            bus.IN_PARITY = ^bus.IN_DATA;
            @(negedge clk);
        end
        bus.IN_DATA   = 16'h5A5A;
        bus.IN_PARITY = ^bus.IN_DATA;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.IN_VALID = 1'b0;
        checks++;
        if (array_out !== '0 || array_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_array got=%h v=%b exp=0 v=0", array_out, array_valid);
        end
        checks++;
        if (busy !== 1'b0 || error !== 1'b0 || bus.IN_READY !== 1'b0 || row_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_ctrl busy=%b err=%b ready=%b row=%0d exp=0", busy, error, bus.IN_READY, row_cnt);
        end
        exp_a = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            bus.IN_VALID  = 1'b1;
            bus.IN_DATA   = 16'h8000 >> r;
            bus.IN_PARITY = ^bus.IN_DATA;
            exp_a[r*16 +: 16] = 16'h8000 >> r;
            @(negedge clk);
        end
        bus.IN_VALID = 1'b0;
        @(negedge clk);
        checks++;
        if (array_out !== exp_a || array_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_frame got=%h v=%b exp=%h v=1", array_out, array_valid, exp_a);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_valid_toggle();
        test_abort();
        test_start_ignored();
        test_parity();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/array_loader.md
ARRAY_LOADER -- requirements
Module: array_loader

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of array rows loaded per frame.
REQ-002 SHALL have parameter COLS, default 16, width of one row word in bits.
REQ-003 SHALL have port FPGA_CLK_50  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port START  input  1  single-cycle request to begin loading a frame.
REQ-006 SHALL have port ABORT  input  1  single-cycle request to discard the frame in progress.
REQ-007 SHALL have port IN_VALID  input  1  row word present on IN_DATA.
REQ-008 SHALL have port IN_READY  output  1  loader accepts a row word this cycle.
REQ-009 SHALL have port IN_DATA  input  COLS  row word, bit c = cell column c.
REQ-010 SHALL have port IN_PARITY  input  1  even-parity bit for IN_DATA; ignored unless parity is compiled in.
REQ-011 SHALL have port ARRAY_OUT  output  ROWS*COLS  committed array, row r on bits [r*COLS +: COLS].
REQ-012 SHALL have port ARRAY_VALID  output  1  ARRAY_OUT holds a fully committed frame.
REQ-013 SHALL have port BUSY  output  1  high in LOAD and COMMIT.
REQ-014 SHALL have port ERROR  output  1  high in ERR.
REQ-015 SHALL have port ROW_CNT  output  $clog2(ROWS)  index of the next row to be accepted.

Function
REQ-016 SHALL implement states IDLE, LOAD, COMMIT, ERR, one-hot or binary at implementer's choice.
REQ-017 SHALL keep a shadow buffer of ROWS x COLS bits, separate from ARRAY_OUT (double buffering).
REQ-018 SHALL, in IDLE, drive IN_READY=0, BUSY=0; START=1 and ABORT=0 -> LOAD with ROW_CNT=0 on the next edge.
REQ-019 SHALL, in LOAD, drive IN_READY=1 combinationally from state only (no dependency on IN_VALID).
REQ-020 SHALL accept a beat only when IN_VALID=1 and IN_READY=1: shadow[ROW_CNT]<=IN_DATA, ROW_CNT<=ROW_CNT+1.
REQ-021 SHALL, on acceptance with ROW_CNT=ROWS-1, go to COMMIT and set ROW_CNT to 0 (no wrap beyond ROWS-1).
REQ-022 SHALL, in COMMIT (exactly one cycle, IN_READY=0), copy shadow into ARRAY_OUT and set ARRAY_VALID=1 on the leaving edge, then go IDLE.
REQ-023 SHALL make ARRAY_OUT visible two edges after the last beat is accepted; ARRAY_OUT SHALL never show a partial frame.
REQ-024 SHALL ignore START while in LOAD or COMMIT.
REQ-025 SHALL, on ABORT=1 in LOAD, go IDLE next edge, ROW_CNT=0, beat offered that cycle NOT accepted, ARRAY_OUT and ARRAY_VALID unchanged.
REQ-026 SHALL give ABORT priority over START and over beat acceptance in the same cycle; ABORT in IDLE, COMMIT or ERR SHALL have no effect.
REQ-027 SHALL hold ARRAY_VALID=1 once set until reset; a new frame replaces ARRAY_OUT only at COMMIT.

Reset
REQ-028 SHALL, on RESET_N=0 at a rising edge, force IDLE, ROW_CNT=0, ARRAY_OUT=0, ARRAY_VALID=0, ERROR=0, BUSY=0, IN_READY=0.
REQ-029 SHALL, on reset mid-LOAD, discard the shadow contents; shadow buffer itself need not be cleared.

Configuration
REQ-030 SHALL compile parity checking in only when ARRAY_LOADER_PARITY_EN is defined.
REQ-031 SHALL, with ARRAY_LOADER_PARITY_EN, on an accepted beat with XOR(IN_DATA, IN_PARITY)=1, not write shadow, go ERR, drive ERROR=1, IN_READY=0.
REQ-032 SHALL, in ERR, leave ARRAY_OUT/ARRAY_VALID unchanged; START -> LOAD with ROW_CNT=0 and ERROR=0 next edge; only START or reset exits ERR.
REQ-033 SHALL, without ARRAY_LOADER_PARITY_EN, ignore IN_PARITY, tie ERROR to 0, and make ERR unreachable.

Verification
REQ-034 SHALL cover: reset, START, 16 beats IN_DATA=16'h0001<<r with IN_VALID always 1 -> ARRAY_OUT row r = 1<<r, ARRAY_VALID=1 two edges after beat 15, BUSY low after.
REQ-035 SHALL cover: same frame with IN_VALID toggling 1/0 every cycle -> identical ARRAY_OUT, ROW_CNT advancing only on accepted beats.
REQ-036 SHALL cover: frame A committed, then START, 7 beats, ABORT -> ARRAY_OUT still frame A, ROW_CNT=0, IDLE; ABORT+START same cycle in LOAD -> IDLE.
REQ-037 SHALL cover: START asserted during beats 3..5 of a load -> ignored, frame commits after 16 beats exactly.
REQ-038 SHALL cover (ARRAY_LOADER_PARITY_EN): beat 4 with IN_DATA=16'h0003, IN_PARITY=1 -> ERROR=1, IN_READY=0, ARRAY_OUT unchanged; START -> ERROR=0, ROW_CNT=0.
REQ-039 SHALL cover: RESET_N=0 during beat 10 -> all outputs zero next edge, subsequent full frame loads correctly.
